// File: rtl/ntt_stream_iter.sv
// Streaming N-point cyclic NTT/INTT over Z_Q: bit-reversed load, in-place radix-2 DIT
// butterflies (one per cycle), optional N^-1 scaling, natural-order unload.
module ntt_stream_iter #(
  parameter int W         = 16,
  parameter int Q         = 7681,
  parameter int N         = 4,
  parameter int LOGN      = 2,
  parameter int OMEGA     = 3383,
  parameter int OMEGA_INV = 4298,
  parameter int N_INV     = 5761
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam logic [2*W-1:0]  QL         = (2*W)'(Q);
  localparam logic [W-1:0]    QW         = W'(Q);
  localparam logic [W-1:0]    NI         = W'(N_INV);
  localparam logic [LOGN-1:0] LAST       = LOGN'(N - 1);
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % QL);
  endfunction

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + {1'b0, QW};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] reduce_in(input logic [W-1:0] d);
    return (d >= QW) ? d - QW : d;
  endfunction

  function automatic logic [W-1:0] pow_mod(input logic [W-1:0] base, input int e);
    logic [W-1:0] r;
    r = W'(1);
    for (int i = 0; i < e; i++) r = mod_mul(r, base);
    return r;
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  typedef enum logic [1:0] {S_LOAD, S_BFLY, S_SCALE, S_UNLOAD} state_t;

  state_t          state_q;
  logic [LOGN-1:0] idx_q;
  logic [LOGN-1:0] stage_q;
  logic            inv_q;
  logic [W-1:0]    mem_q [N];

  logic [W-1:0] tw_f [N/2];
  logic [W-1:0] tw_i [N/2];

  for (genvar j = 0; j < N/2; j++) begin : g_tw
    localparam logic [W-1:0] TF = pow_mod(W'(OMEGA), j);
    localparam logic [W-1:0] TI = pow_mod(W'(OMEGA_INV), j);
    assign tw_f[j] = TF;
    assign tw_i[j] = TI;
  end

  // Butterfly j of stage s pairs (top, top + 2^s) with twiddle index pos * N / 2^(s+1)
  logic [LOGN-1:0] j_w, one_w, pos_w, top_w, bot_w;
  logic [LOGN-2:0] tix_w;
  logic [W-1:0]    a_w, b_w, tw_w, t_w, bf_hi, bf_lo;

  always_comb begin
    j_w   = {1'b0, idx_q[LOGN-2:0]};
    one_w = LOGN'(1) << stage_q;
    pos_w = j_w & (one_w - LOGN'(1));
    top_w = ((j_w >> stage_q) << (stage_q + LOGN'(1))) | pos_w;
    bot_w = top_w | one_w;
    tix_w = (LOGN-1)'(pos_w << (LAST_STAGE - stage_q));
    a_w   = mem_q[top_w];
    b_w   = mem_q[bot_w];
    tw_w  = inv_q ? tw_i[tix_w] : tw_f[tix_w];
    t_w   = mod_mul(tw_w, b_w);
    bf_hi = mod_add(a_w, t_w);
    bf_lo = mod_sub(a_w, t_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: if (in_valid) begin
          if (idx_q == '0) inv_q <= inv;
          idx_q <= idx_q + LOGN'(1);
          if (idx_q == LAST) state_q <= S_BFLY;
        end
        S_BFLY: begin
          if (idx_q[LOGN-2:0] == '1) begin
            idx_q <= '0;
            if (stage_q == LAST_STAGE) begin
              stage_q <= '0;
              state_q <= inv_q ? S_SCALE : S_UNLOAD;
            end else begin
              stage_q <= stage_q + LOGN'(1);
            end
          end else begin
            idx_q <= idx_q + LOGN'(1);
          end
        end
        S_SCALE: begin
          idx_q <= idx_q + LOGN'(1);
          if (idx_q == LAST) state_q <= S_UNLOAD;
        end
        S_UNLOAD: if (out_ready) begin
          idx_q <= idx_q + LOGN'(1);
          if (idx_q == LAST) state_q <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Coefficient buffer: never reset, only exposed while unloading
  always_ff @(posedge clk) begin
    case (state_q)
      S_LOAD:  if (in_valid && in_ready) mem_q[bitrev(idx_q)] <= reduce_in(in_data);
      S_BFLY: begin
        mem_q[top_w] <= bf_hi;
        mem_q[bot_w] <= bf_lo;
      end
      S_SCALE: mem_q[idx_q] <= mod_mul(mem_q[idx_q], NI);
      default: ;
    endcase
  end

  assign in_ready  = !rst && (state_q == S_LOAD);
  assign out_valid = !rst && (state_q == S_UNLOAD);
  assign out_data  = out_valid ? mem_q[idx_q] : '0;
  assign out_last  = out_valid && (idx_q == LAST);
  assign busy      = !rst && (state_q != S_LOAD);

endmodule

// File: tb/tb_ntt_stream_iter.sv
// Directed bench for ntt_stream_iter: N=4 vectors, reset cases, round trips, and an N=256 instance.
module tb_ntt_stream_iter;
  localparam int W = 16;
  localparam int Q = 7681;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, inv, in_valid, out_ready, sel;
  logic [W-1:0] in_data;

  logic         a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [W-1:0] a_out_data;
  logic         b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [W-1:0] b_out_data;
  logic         a_in_valid, b_in_valid, a_out_ready, b_out_ready;
  logic         in_ready, out_valid, out_last, busy;
  logic [W-1:0] out_data;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_out_ready = out_ready & sel;
  assign in_ready    = sel ? b_in_ready  : a_in_ready;
  assign out_valid   = sel ? b_out_valid : a_out_valid;
  assign out_last    = sel ? b_out_last  : a_out_last;
  assign out_data    = sel ? b_out_data  : a_out_data;
  assign busy        = sel ? b_busy      : a_busy;

  ntt_stream_iter u_dut (
    .clk(clk), .rst(rst), .inv(inv),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
  );

  // 198 has order 256 mod 7681; its inverse is 1125 (198*1125 = 29*7681 + 1)
  ntt_stream_iter #(
    .W(16), .Q(7681), .N(256), .LOGN(8), .OMEGA(198), .OMEGA_INV(1125), .N_INV(7651)
  ) u_dut256 (
    .clk(clk), .rst(rst), .inv(inv),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  int n_run  = 0;
  int n_fail = 0;
  int nn     = 4;
  int logn   = 2;

  logic [W-1:0] xv   [256];
  logic [W-1:0] yv   [256];
  logic [W-1:0] ev   [256];
  logic [W-1:0] orig [256];
  longint       pw   [256];

  int vin  [6][4];
  int vexp [6][4];
  bit viv  [6];
  bit vst  [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int cnt, input bit iv);
    int tmo;
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_data  = xv[i];
      inv      = (i == 0) ? iv : ~iv;
      tmo = 0;
      while (!in_ready && tmo < 5000) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 5000) begin
        chk("send_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input bit stall, input int beats, output int lat);
    int cnt, k, guard;
    bit held;
    logic [W-1:0] hold_d;
    logic hold_l;
    cnt = 0;
    while (!out_valid && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    lat = cnt + 1;
    if (cnt >= 5000) begin
      chk("out_valid_timeout", 1, 0);
      return;
    end
    k = 0; guard = 0; held = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (k < beats && guard < 20000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("out_valid", out_valid, 1);
      chk("in_ready_unload", in_ready, 0);
      if (held) begin
        chk("stall_data", out_data, hold_d);
        chk("stall_last", out_last, hold_l);
      end
      if (out_ready) begin
        yv[k] = out_data;
        chk("out_last", out_last, (k == nn - 1) ? 1 : 0);
        k++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        hold_d = out_data;
        hold_l = out_last;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (guard >= 20000) chk("recv_timeout", 1, 0);
    if (beats == nn) chk("in_ready_after", in_ready, 1);
  endtask

  task automatic run(input bit iv, input bit stall);
    int lat;
    send(nn, iv);
    recv(stall, nn, lat);
    chk("latency", lat, nn / 2 * logn + 1 + (iv ? nn : 0));
  endtask

  task automatic model256();
    longint acc;
    for (int k = 0; k < 256; k++) begin
      acc = 0;
      for (int n = 0; n < 256; n++)
        acc = (acc + (longint'(xv[n]) % Q) * pw[(n * k) % 256]) % Q;
      ev[k] = W'(acc);
    end
  endtask

  initial begin
    vin  = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{1, 1, 1, 1}, '{4, 0, 0, 0}, '{7681, 0, 0, 0}, '{0, 0, 1, 0}};
    vexp = '{'{1, 1, 1, 1}, '{1, 3383, 7680, 4298}, '{4, 0, 0, 0}, '{1, 1, 1, 1}, '{0, 0, 0, 0},
             '{5761, 1920, 5761, 1920}};
    viv  = '{0, 0, 0, 1, 0, 1};
    vst  = '{0, 1, 0, 1, 0, 0};
    pw[0] = 1;
    for (int i = 1; i < 256; i++) pw[i] = (pw[i-1] * 198) % Q;

    rst = 1'b1; sel = 1'b0; inv = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int d = 0; d < 6; d++) begin
      for (int i = 0; i < 4; i++) xv[i] = W'(vin[d][i]);
      run(viv[d], vst[d]);
      for (int i = 0; i < 4; i++) chk($sformatf("vec%0d[%0d]", d, i), yv[i], vexp[d][i]);
    end

    // reset after two input beats
    for (int i = 0; i < 4; i++) xv[i] = W'(i + 5);
    send(2, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstload_in_ready", in_ready, 0);
    chk("rstload_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstload_in_ready_after", in_ready, 1);
    xv[0] = 0; xv[1] = 1; xv[2] = 0; xv[3] = 0;
    run(1'b0, 1'b0);
    chk("rstload_x0", yv[0], 1);
    chk("rstload_x1", yv[1], 3383);
    chk("rstload_x2", yv[2], 7680);
    chk("rstload_x3", yv[3], 4298);

    // reset after two output beats
    begin
      int lat;
      xv[0] = 1; xv[1] = 0; xv[2] = 0; xv[3] = 0;
      send(4, 1'b0);
      recv(1'b0, 2, lat);
    end
    rst = 1'b1;
    #1;
    chk("rstunl_out_valid", out_valid, 0);
    chk("rstunl_out_data", out_data, 0);
    chk("rstunl_out_last", out_last, 0);
    chk("rstunl_busy", busy, 0);
    chk("rstunl_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstunl_in_ready_after", in_ready, 1);
    chk("rstunl_out_valid_after", out_valid, 0);
    xv[0] = 1; xv[1] = 1; xv[2] = 1; xv[3] = 1;
    run(1'b0, 1'b0);
    chk("rstunl_x0", yv[0], 4);
    chk("rstunl_x1", yv[1], 0);
    chk("rstunl_x2", yv[2], 0);
    chk("rstunl_x3", yv[3], 0);

    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 4; i++) begin
        orig[i] = W'($urandom_range(0, Q));
        xv[i]   = orig[i];
      end
      run(1'b0, f[0]);
      for (int i = 0; i < 4; i++) xv[i] = yv[i];
      run(1'b1, ~f[0]);
      for (int i = 0; i < 4; i++) chk("rt4", yv[i], orig[i] % Q);
    end

    sel = 1'b1; nn = 256; logn = 8;
    @(negedge clk);
    for (int i = 0; i < 256; i++) xv[i] = (i == 0) ? 1 : 0;
    run(1'b0, 1'b0);
    for (int i = 0; i < 256; i++) chk("n256_impulse", yv[i], 1);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 256; i++) xv[i] = W'($urandom_range(0, Q));
      model256();
      run(1'b0, 1'b0);
      for (int i = 0; i < 256; i++) chk("n256_fwd", yv[i], ev[i]);
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 256; i++) begin
        orig[i] = W'($urandom_range(0, Q));
        xv[i]   = orig[i];
      end
      run(1'b0, 1'b0);
      for (int i = 0; i < 256; i++) xv[i] = yv[i];
      run(1'b1, 1'b0);
      for (int i = 0; i < 256; i++) chk("n256_rt", yv[i], orig[i] % Q);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
